// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The optional misalign check is enabled by defining IFU_MISALIGN_CHK_EN.
package ifu_pkg;
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } ifu_state_t;
endpackage

// File: rtl/ifu_pc.sv
// PC register and next-PC selection (hold / sequential step / redirect).
// With IFU_MISALIGN_CHK_EN defined, flags redirect targets that are not word aligned.
module ifu_pc
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] target,
    output logic            bad
);
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

`ifdef IFU_MISALIGN_CHK_EN
    assign target = redirect_pc;
    assign bad    = (redirect_pc[1:0] != 2'b00);
`else
    // Without the check, low bits are simply dropped so every fetch is word aligned.
    assign target = redirect_pc & ~32'h3;
    assign bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)           pc <= RESET_PC;
        else if (redirect) pc <= target;
        else if (advance)  pc <= pc + STEP;
    end
endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: single outstanding fetch, {pc, inst} held for decode
// under valid/ready, redirects from execute. Optional macro: IFU_MISALIGN_CHK_EN.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i_ifu,
    input  logic [31:0] redirect_pc_i_ifu,
    output logic        imem_req_o_ifu,
    output logic [31:0] imem_addr_o_ifu,
    input  logic        imem_rvalid_i_ifu,
    input  logic [31:0] imem_rdata_i_ifu,
    output logic        valid_o_ifu,
    input  logic        ready_i_ifu,
    output logic [31:0] pc_o_ifu,
    output logic [31:0] inst_o_ifu,
    output logic        misalign_o_ifu
);
    ifu_state_t  state, state_nx;
    logic        redir;
    logic        bad;
    logic        drop_q;
    logic        mis_q;
    logic        advance;
    logic [31:0] pc;
    logic [31:0] target;

    assign redir   = redirect_i_ifu && (state != S_RST);
    // A misaligned-target hold only leaves on a redirect, never on ready.
    assign advance = (state == S_HOLD) && ready_i_ifu && !redir && !mis_q;

    ifu_pc #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redir),
        .redirect_pc (redirect_pc_i_ifu),
        .advance     (advance),
        .pc          (pc),
        .target      (target),
        .bad         (bad)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_RST;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RST:  state_nx = S_REQ;
            S_REQ:  begin
                if (redir) state_nx = bad ? S_HOLD : S_REQ;
                else       state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (redir)                  state_nx = bad ? S_HOLD : (imem_rvalid_i_ifu ? S_REQ : S_WAIT);
                else if (imem_rvalid_i_ifu) state_nx = drop_q ? S_REQ : S_HOLD;
            end
            S_HOLD: begin
                if (redir)        state_nx = bad ? S_HOLD : S_REQ;
                else if (advance) state_nx = S_REQ;
            end
            default: state_nx = S_RST;
        endcase
    end

    always_comb begin
        imem_req_o_ifu  = (state == S_REQ) && !redir;
        imem_addr_o_ifu = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o_ifu <= 1'b0;
            pc_o_ifu    <= 32'b0;
            inst_o_ifu  <= 32'b0;
            drop_q      <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            // A response still in flight when the unit leaves S_WAIT is tracked until it lands.
            if ((state == S_WAIT) && redir && !imem_rvalid_i_ifu) drop_q <= 1'b1;
            else if (imem_rvalid_i_ifu)                           drop_q <= 1'b0;

            if (redir && bad) begin
                valid_o_ifu <= 1'b1;
                pc_o_ifu    <= target;
                inst_o_ifu  <= 32'b0;
                mis_q       <= 1'b1;
            end else if (redir) begin
                valid_o_ifu <= 1'b0;
                mis_q       <= 1'b0;
            end else if ((state == S_WAIT) && imem_rvalid_i_ifu && !drop_q) begin
                valid_o_ifu <= 1'b1;
                pc_o_ifu    <= pc;
                inst_o_ifu  <= imem_rdata_i_ifu;
                mis_q       <= 1'b0;
            end else if (advance) begin
                valid_o_ifu <= 1'b0;
            end
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    assign misalign_o_ifu = mis_q;
`else
    assign misalign_o_ifu = 1'b0;
`endif
endmodule
